result_display_driver: RTL

Output-side counterpart to the keypad entry path: takes a binary result (e.g. divider quotient or remainder) and presents it to the user on the board's 4-digit multiplexed 7-segment display.
- Converts the loaded value to decimal with a sequential shift-add-3 (double-dabble) engine.
- Commits all four digits atomically when conversion finishes.
- Time-multiplexes the digits onto anodo/seven.
- Sits between the divider datapath and the board pins.

---
 rtl/display_pkg.sv | 50 +++++
 rtl/bcd_converter_seq.sv | 73 +++++++
 rtl/result_display_driver.sv | 98 +++++++++
 3 files changed

// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - digit codes, segment patterns and decoder for the result display
package display_pkg;

    typedef logic [3:0] digit_code_t;

    localparam digit_code_t D_BLANK = 4'hA;
    localparam digit_code_t D_DASH  = 4'hB;

    // Active-low segments, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [3:0] ANODE_OFF = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_COMMIT
    } conv_state_t;

    function automatic logic [6:0] seg_decode(input digit_code_t d);
        logic [6:0] seg;
        case (d)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            D_DASH:  seg = SEG_DASH;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bcd_converter_seq.sv
// rtl/bcd_converter_seq.sv - sequential shift-add-3 binary to 4-digit BCD converter
module bcd_converter_seq
    import display_pkg::*;
#(
    parameter int VAL_W = 14
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [VAL_W-1:0]      value,
    output logic                  busy,
    output logic                  done,
    output logic [3:0][3:0]       bcd,
    output logic                  overflow
);

    localparam int CNT_W = (VAL_W > 1) ? $clog2(VAL_W) : 1;

    conv_state_t      state;
    logic [VAL_W-1:0] bin;
    logic [CNT_W-1:0] shift_cnt;
    logic [3:0][3:0]  adj;

    always_comb begin
        adj = bcd;
        for (int i = 0; i < 4; i++) begin
            if (bcd[i] >= 4'd5) begin
                adj[i] = bcd[i] + 4'd3;
            end
        end
    end

    // Any bit leaving the top nibble means a fifth decimal digit exists; keep it sticky.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            bin       <= '0;
            bcd       <= '0;
            overflow  <= 1'b0;
            shift_cnt <= '0;
        end else begin
            done <= 1'b0;
            if (load) begin
                state     <= ST_SHIFT;
                busy      <= 1'b1;
                bin       <= value;
                bcd       <= '0;
                overflow  <= 1'b0;
                shift_cnt <= '0;
            end else begin
                case (state)
                    ST_SHIFT: begin
                        {bcd, bin} <= {adj, bin} << 1;
                        overflow   <= overflow | adj[3][3];
                        if (shift_cnt == CNT_W'(VAL_W - 1)) begin
                            state <= ST_COMMIT;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            shift_cnt <= shift_cnt + 1'b1;
                        end
                    end
                    ST_COMMIT: state <= ST_IDLE;
                    default:   state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/result_display_driver.sv
// rtl/result_display_driver.sv - binary result to multiplexed 4-digit 7-segment display
module result_display_driver
    import display_pkg::*;
#(
    parameter int VAL_W       = 14,
    parameter int REFRESH_DIV = 50000,
    parameter bit BLANK_LZ    = 1'b1
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [VAL_W-1:0] value,
    output logic             busy,
    output logic             done,
    output logic [3:0]       anodo,
    output logic [6:0]       seven
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic            conv_busy;
    logic            conv_done;
    logic            conv_ovf;
    logic [3:0][3:0] conv_bcd;

    digit_code_t      digits      [4];
    digit_code_t      next_digits [4];
    logic [CNT_W-1:0] refresh_cnt;
    logic [1:0]       digit_idx;

    bcd_converter_seq #(
        .VAL_W (VAL_W)
    ) u_conv (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .value    (value),
        .busy     (conv_busy),
        .done     (conv_done),
        .bcd      (conv_bcd),
        .overflow (conv_ovf)
    );

    // Blank zeros above the most significant nonzero digit; units always shown.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            next_digits[i] = conv_bcd[i];
        end
        if (conv_ovf) begin
            for (int i = 0; i < 4; i++) begin
                next_digits[i] = D_DASH;
            end
        end else if (BLANK_LZ) begin
            if (conv_bcd[3] == 4'd0) begin
                next_digits[3] = D_BLANK;
                if (conv_bcd[2] == 4'd0) begin
                    next_digits[2] = D_BLANK;
                    if (conv_bcd[1] == 4'd0) begin
                        next_digits[1] = D_BLANK;
                    end
                end
            end
        end
    end

    // busy/done trail the converter by one cycle so digits and done land on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            refresh_cnt <= '0;
            digit_idx   <= 2'd0;
            anodo       <= ANODE_OFF;
            seven       <= SEG_BLANK;
            for (int i = 0; i < 4; i++) begin
                digits[i] <= D_BLANK;
            end
        end else begin
            busy <= conv_busy;
            done <= conv_done;
            if (conv_done) begin
                for (int i = 0; i < 4; i++) begin
                    digits[i] <= next_digits[i];
                end
            end
            if (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
                refresh_cnt <= '0;
                digit_idx   <= digit_idx + 2'd1;
            end else begin
                refresh_cnt <= refresh_cnt + 1'b1;
            end
            anodo <= ~(4'b0001 << digit_idx);
            seven <= seg_decode(digits[digit_idx]);
        end
    end

endmodule
